// File: rtl/cnu_ms_pipe.sv
// Offset min-sum LDPC check node unit: packed v2c set in, packed c2v set plus min1 edge index out.
// Latency: three register stages (S1 input, S2 min-finder, S3 output); one beat per cycle.
// Backpressure: single advance enable (~out_valid | out_ready) freezes every stage; in_ready = advance.
// Optional: define CNU_NORM_SCALE_EN for normalized-offset min-sum (mag - (mag >> ALPHA_SHIFT) before offset).
module cnu_ms_pipe #(
  parameter int CN_DEGREE   = 6,
  parameter int QUAN_SIZE   = 4,
  parameter int MAG_SIZE    = QUAN_SIZE - 1,
  parameter int IDX_W       = $clog2(CN_DEGREE),
  parameter int OFFSET      = 1,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic                           sys_clk,
  input  logic                           rstn,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CN_DEGREE*QUAN_SIZE-1:0] v2c_msg,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CN_DEGREE*QUAN_SIZE-1:0] c2v_msg,
  output logic [IDX_W-1:0]               min1_idx
);

  localparam int W = CN_DEGREE * QUAN_SIZE;

  // Reject illegal configurations at elaboration time.
  if (CN_DEGREE < 2 || CN_DEGREE > 32 || MAG_SIZE != QUAN_SIZE - 1 || ALPHA_SHIFT < 0) begin : g_param_err
    $error("cnu_ms_pipe: illegal parameter combination");
  end

  logic adv;

  // S1 state
  logic                 s1_vld;
  logic [W-1:0]         s1_dat;
  logic [CN_DEGREE-1:0] s1_sgn;
  logic [MAG_SIZE-1:0]  s1_mag [CN_DEGREE];

  // S2 combinational results and state
  logic [MAG_SIZE-1:0]  min1_c;
  logic [MAG_SIZE-1:0]  min2_c;
  logic [IDX_W-1:0]     idx_c;
  logic                 sgn_all_c;
  logic                 s2_vld;
  logic [MAG_SIZE-1:0]  s2_min1;
  logic [MAG_SIZE-1:0]  s2_min2;
  logic [IDX_W-1:0]     s2_idx;
  logic                 s2_sgn_all;
  logic [CN_DEGREE-1:0] s2_sgn;

  // S3 combinational results
  logic [W-1:0]         c2v_c;
  logic [MAG_SIZE-1:0]  sel_mag;
  logic [MAG_SIZE:0]    diff;
  logic [MAG_SIZE-1:0]  out_mag;
  logic                 out_sgn;

  // A whole-pipe stall happens only when the output holds a beat nobody takes.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // S1: capture the raw v2c beat.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else if (adv) begin
      s1_vld <= in_valid;
      s1_dat <= v2c_msg;
    end
  end

  // Split each registered message into sign and magnitude.
  always_comb begin
    s1_sgn = '0;
    for (int i = 0; i < CN_DEGREE; i++) begin
      s1_sgn[i] = s1_dat[i*QUAN_SIZE + MAG_SIZE];
      s1_mag[i] = s1_dat[i*QUAN_SIZE +: MAG_SIZE];
    end
  end

  // Running two-minimum search; strict '<' keeps the lowest index on ties,
  // and a tied value still lands in min2 so min2 == min1 in that case.
  always_comb begin
    min1_c    = '1;
    min2_c    = '1;
    idx_c     = '0;
    sgn_all_c = ^s1_sgn;
    for (int i = 0; i < CN_DEGREE; i++) begin
      if (s1_mag[i] < min1_c) begin
        min2_c = min1_c;
        min1_c = s1_mag[i];
        idx_c  = IDX_W'(i);
      end else if (s1_mag[i] < min2_c) begin
        min2_c = s1_mag[i];
      end
    end
  end

  // S2: register the minima, the overall sign parity and the per-edge signs.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      s2_vld     <= 1'b0;
      s2_min1    <= '0;
      s2_min2    <= '0;
      s2_idx     <= '0;
      s2_sgn_all <= 1'b0;
      s2_sgn     <= '0;
    end else if (adv) begin
      s2_vld     <= s1_vld;
      s2_min1    <= min1_c;
      s2_min2    <= min2_c;
      s2_idx     <= idx_c;
      s2_sgn_all <= sgn_all_c;
      s2_sgn     <= s1_sgn;
    end
  end

  // Build each c2v message: extrinsic minimum, optional scaling, clamped offset, no negative zero.
  always_comb begin
    c2v_c   = '0;
    sel_mag = '0;
    diff    = '0;
    out_mag = '0;
    out_sgn = 1'b0;
    for (int i = 0; i < CN_DEGREE; i++) begin
      sel_mag = (IDX_W'(i) == s2_idx) ? s2_min2 : s2_min1;
`ifdef CNU_NORM_SCALE_EN
      sel_mag = sel_mag - (sel_mag >> ALPHA_SHIFT);
`endif
      diff    = {1'b0, sel_mag} - (MAG_SIZE+1)'(OFFSET);
      out_mag = diff[MAG_SIZE] ? '0 : diff[MAG_SIZE-1:0];
      out_sgn = (out_mag != '0) & (s2_sgn_all ^ s2_sgn[i]);
      c2v_c[i*QUAN_SIZE +: QUAN_SIZE] = {out_sgn, out_mag};
    end
  end

  // S3: output register, held while the consumer stalls.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      c2v_msg   <= '0;
      min1_idx  <= '0;
    end else if (adv) begin
      out_valid <= s2_vld;
      c2v_msg   <= c2v_c;
      min1_idx  <= s2_idx;
    end
  end

endmodule
